// File: rtl/bp_predecoder_ras_if.sv
// Fetch-side bundle between instruction memory, the predecoder and the fetch PC mux.
// The master drives the packet and backend redirect; the slave returns the prediction.

interface bp_predecoder_ras_if #(
   parameter int unsigned FETCH_W   = 2,
   parameter int unsigned RAS_DEPTH = 8
);

   localparam int unsigned SlotW = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
   localparam int unsigned CntW  = $clog2(RAS_DEPTH) + 1;

   logic [32*FETCH_W-1:0] instruction;
   logic [31:0]           pc_late;
   logic                  imem_resp;
   logic                  mispredict;
   logic [31:0]           pc_target_addr;
   logic                  valid;
   logic [SlotW-1:0]      slot_idx;
   logic                  jump_valid1;
   logic                  jump_valid2;
   logic [CntW-1:0]       ras_count;

   modport master (
      output instruction,
      output pc_late,
      output imem_resp,
      output mispredict,
      input  pc_target_addr,
      input  valid,
      input  slot_idx,
      input  jump_valid1,
      input  jump_valid2,
      input  ras_count
   );

   modport slave (
      input  instruction,
      input  pc_late,
      input  imem_resp,
      input  mispredict,
      output pc_target_addr,
      output valid,
      output slot_idx,
      output jump_valid1,
      output jump_valid2,
      output ras_count
   );

endinterface

// File: rtl/bp_predecoder_ras.sv
// Fetch-packet predecoder: finds the first control-flow slot and predicts its target.
// Define BP_RAS_EN to build in the return address stack; otherwise JALR never predicts.

module bp_predecoder_ras #(
   parameter int unsigned FETCH_W   = 2,
   parameter int unsigned RAS_DEPTH = 8
) (
   input logic                clk,
   input logic                rst,
   bp_predecoder_ras_if.slave bus
);

   localparam int unsigned SlotW = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;

   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;

   logic             squash_q, squash_d;
   logic             en;
   logic [31:0]      target;
   logic             pred_valid;
   logic             pred_jal;
   logic             pred_ret;
   logic [SlotW-1:0] pred_slot;

`ifdef BP_RAS_EN
   localparam int unsigned PtrW = $clog2(RAS_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {RasNone, RasPush, RasPop, RasSwap} ras_op_e;

   function automatic logic is_link(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   logic [31:0]     ras_q [RAS_DEPTH];
   logic [31:0]     ras_d [RAS_DEPTH];
   logic [PtrW-1:0] ptr_q, ptr_d;
   logic [PtrW-1:0] top_idx;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     ras_top;
   ras_op_e         ras_op;
   logic [31:0]     link_addr;

   // ptr_q is the next write slot; the top of stack sits just below it.
   assign top_idx = ptr_q - PtrW'(1);
   assign ras_top = ras_q[top_idx];
`endif

   // A response arriving while squash is armed belongs to the wrong path.
   assign en = rst && bus.imem_resp && !squash_q && !bus.mispredict;

   always_comb begin
      squash_d = squash_q;
      if (bus.mispredict) begin
         squash_d = 1'b1;
      end else if (bus.imem_resp) begin
         squash_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         squash_q <= 1'b0;
      end else begin
         squash_q <= squash_d;
      end
   end

   // Slot scan: the first JAL, backward branch or JALR terminates the packet.
   always_comb begin
      logic        found;
      logic [31:0] ins;
      logic [31:0] spc;
      logic [31:0] j_imm;
      logic [31:0] b_imm;
`ifdef BP_RAS_EN
      logic        rd_link;
      logic        rs1_link;
`endif
      found      = 1'b0;
      ins        = '0;
      spc        = '0;
      j_imm      = '0;
      b_imm      = '0;
      target     = '0;
      pred_valid = 1'b0;
      pred_jal   = 1'b0;
      pred_ret   = 1'b0;
      pred_slot  = '0;
`ifdef BP_RAS_EN
      rd_link    = 1'b0;
      rs1_link   = 1'b0;
      ras_op     = RasNone;
      link_addr  = '0;
`endif
      for (int i = 0; i < int'(FETCH_W); i++) begin
         ins   = bus.instruction[32*i +: 32];
         spc   = bus.pc_late + (32'(i) << 2);
         j_imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
         b_imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
         if (!found) begin
            case (ins[6:0])
               OpJal: begin
                  found      = 1'b1;
                  pred_slot  = SlotW'(i);
                  pred_valid = 1'b1;
                  pred_jal   = 1'b1;
                  target     = spc + j_imm;
`ifdef BP_RAS_EN
                  link_addr  = spc + 32'd4;
                  if (is_link(ins[11:7])) begin
                     ras_op = RasPush;
                  end
`endif
               end
               OpBranch: begin
                  if (ins[31]) begin
                     found      = 1'b1;
                     pred_slot  = SlotW'(i);
                     pred_valid = 1'b1;
                     target     = spc + b_imm;
                  end
               end
               OpJalr: begin
                  found     = 1'b1;
                  pred_slot = SlotW'(i);
`ifdef BP_RAS_EN
                  rd_link   = is_link(ins[11:7]);
                  rs1_link  = is_link(ins[19:15]);
                  link_addr = spc + 32'd4;
                  if (rd_link && (!rs1_link || (ins[11:7] == ins[19:15]))) begin
                     ras_op = RasPush;
                  end else if (rs1_link && !rd_link) begin
                     ras_op = RasPop;
                  end else if (rs1_link) begin
                     ras_op = RasSwap;
                  end
                  if (((ras_op == RasPop) || (ras_op == RasSwap)) && (cnt_q != '0)) begin
                     pred_valid = 1'b1;
                     pred_ret   = 1'b1;
                     target     = ras_top & ~32'd1;
                  end
`endif
               end
               default: begin
               end
            endcase
         end
      end
      if (!en) begin
         target     = '0;
         pred_valid = 1'b0;
         pred_jal   = 1'b0;
         pred_ret   = 1'b0;
         pred_slot  = '0;
`ifdef BP_RAS_EN
         ras_op     = RasNone;
`endif
      end
   end

`ifdef BP_RAS_EN
   // Circular stack: a push when full overwrites the oldest entry.
   always_comb begin
      ras_d = ras_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (bus.mispredict) begin
         ptr_d = '0;
         cnt_d = '0;
      end else if ((ras_op == RasPush) || ((ras_op == RasSwap) && (cnt_q == '0))) begin
         ras_d[ptr_q] = link_addr;
         ptr_d        = ptr_q + PtrW'(1);
         if (cnt_q != CntW'(RAS_DEPTH)) begin
            cnt_d = cnt_q + CntW'(1);
         end
      end else if (ras_op == RasSwap) begin
         ras_d[top_idx] = link_addr;
      end else if ((ras_op == RasPop) && (cnt_q != '0)) begin
         ptr_d = top_idx;
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
         for (int k = 0; k < int'(RAS_DEPTH); k++) begin
            ras_q[k] <= '0;
         end
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         ras_q <= ras_d;
      end
   end

   assign bus.ras_count = rst ? cnt_q : '0;
`else
   assign bus.ras_count = '0;
`endif

   assign bus.pc_target_addr = target;
   assign bus.valid          = pred_valid;
   assign bus.slot_idx       = pred_slot;
   assign bus.jump_valid1    = pred_jal;
   assign bus.jump_valid2    = pred_ret;

endmodule

// File: tb/tb_bp_predecoder_ras.sv
// Bench for bp_predecoder_ras: directed scenarios then random packets, checked against a
// queue-based model that predicts from the generated instruction fields.

module tb_bp_predecoder_ras;

   localparam int unsigned FW    = 2;
   localparam int unsigned RD    = 8;
   localparam int          KJal  = 0;
   localparam int          KBr   = 1;
   localparam int          KJalr = 2;
   localparam int          KOth  = 3;
   localparam int          ANone = 0;
   localparam int          APush = 1;
   localparam int          APop  = 2;
   localparam int          ASwap = 3;

   typedef struct {
      int          kind;
      int          rd;
      int          rs1;
      int          imm;
      logic [31:0] raw;
   } slot_t;

   logic        clk = 1'b0;
   logic        rst;
   slot_t       slots [FW];
   logic [31:0] q_ras [$];
   bit          sq_m;
   int          n_tests;
   int          n_fail;

   always #5 clk = ~clk;

   bp_predecoder_ras_if #(.FETCH_W(FW), .RAS_DEPTH(RD)) bus ();

   bp_predecoder_ras #(.FETCH_W(FW), .RAS_DEPTH(RD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic bit isl(input int r);
      return (r == 1) || (r == 5);
   endfunction

   function automatic slot_t mk(input int kind, input int rd, input int rs1, input int imm);
      slot_t s;
      s.kind = kind;
      s.rd   = rd;
      s.rs1  = rs1;
      s.imm  = imm;
      s.raw  = 32'h0000_0013;
      return s;
   endfunction

   function automatic logic [31:0] enc(input slot_t s);
      logic [31:0] im;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      im  = s.imm;
      rd  = 5'(s.rd);
      rs1 = 5'(s.rs1);
      case (s.kind)
         KJal:    return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
         KBr:     return {im[12], im[10:5], 5'd3, rs1, 3'b001, im[4:1], im[11], 7'h63};
         KJalr:   return {im[11:0], rs1, 3'b000, rd, 7'h67};
         default: return s.raw;
      endcase
   endfunction

   function automatic int pick_reg();
      int r;
      r = int'($urandom_range(0, 3));
      if (r == 0) return 0;
      if (r == 1) return 1;
      if (r == 2) return 5;
      return int'($urandom_range(2, 31));
   endfunction

   function automatic slot_t rnd_slot();
      slot_t       s;
      int          k;
      logic [31:0] w;
      k = int'($urandom_range(0, 9));
      if (k < 3) begin
         s = mk(KJal, pick_reg(), 0, (int'($urandom_range(0, 1048575)) - 524288) * 2);
      end else if (k < 6) begin
         s = mk(KBr, 0, 2, (int'($urandom_range(0, 4095)) - 2048) * 2);
      end else if (k < 9) begin
         s = mk(KJalr, pick_reg(), pick_reg(), int'($urandom_range(0, 4095)));
      end else begin
         s = mk(KOth, 0, 0, 0);
         w = $urandom;
         if (w[6:0] == 7'h6f || w[6:0] == 7'h67 || w[6:0] == 7'h63) begin
            w[6:0] = 7'h33;
         end
         s.raw = w;
      end
      return s;
   endfunction

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   // One clock: drive at the falling edge, compare at +1, then advance the model state.
   task automatic cycle(input logic r, input logic resp, input logic mis, input logic [31:0] pc);
      logic        en;
      logic [31:0] spc;
      logic [31:0] e_tgt;
      logic [31:0] a;
      logic        e_v;
      logic        e_j1;
      logic        e_j2;
      int          e_slot;
      int          e_cnt;
      int          act;
      bit          term;
      @(negedge clk);
      rst            = r;
      bus.imem_resp  = resp;
      bus.mispredict = mis;
      bus.pc_late    = pc;
      for (int i = 0; i < int'(FW); i++) begin
         bus.instruction[32*i +: 32] = enc(slots[i]);
      end
      #1;
      e_tgt  = '0;
      a      = '0;
      e_v    = 1'b0;
      e_j1   = 1'b0;
      e_j2   = 1'b0;
      e_slot = 0;
      act    = ANone;
      term   = 1'b0;
      en     = r && resp && !sq_m && !mis;
      if (en) begin
         for (int i = 0; i < int'(FW) && !term; i++) begin
            spc = pc + 32'(4 * i);
            case (slots[i].kind)
               KJal: begin
                  term   = 1'b1;
                  e_slot = i;
                  e_v    = 1'b1;
                  e_j1   = 1'b1;
                  e_tgt  = spc + 32'(slots[i].imm);
                  a      = spc + 32'd4;
                  if (isl(slots[i].rd)) act = APush;
               end
               KBr: begin
                  if (slots[i].imm < 0) begin
                     term   = 1'b1;
                     e_slot = i;
                     e_v    = 1'b1;
                     e_tgt  = spc + 32'(slots[i].imm);
                  end
               end
               KJalr: begin
                  term   = 1'b1;
                  e_slot = i;
                  a      = spc + 32'd4;
                  if (isl(slots[i].rd) && (!isl(slots[i].rs1) || slots[i].rd == slots[i].rs1))
                     act = APush;
                  else if (isl(slots[i].rs1) && !isl(slots[i].rd))
                     act = APop;
                  else if (isl(slots[i].rs1))
                     act = ASwap;
`ifdef BP_RAS_EN
                  if ((act == APop || act == ASwap) && q_ras.size() > 0) begin
                     e_v   = 1'b1;
                     e_j2  = 1'b1;
                     e_tgt = q_ras[$] & ~32'd1;
                  end
`endif
               end
               default: begin
               end
            endcase
         end
      end
`ifdef BP_RAS_EN
      e_cnt = r ? q_ras.size() : 0;
`else
      e_cnt = 0;
`endif
      check("valid", 32'(bus.valid), 32'(e_v));
      check("target", bus.pc_target_addr, e_tgt);
      check("slot_idx", 32'(bus.slot_idx), 32'(e_slot));
      check("jump_valid1", 32'(bus.jump_valid1), 32'(e_j1));
      check("jump_valid2", 32'(bus.jump_valid2), 32'(e_j2));
      check("ras_count", 32'(bus.ras_count), 32'(e_cnt));
      if (!r) begin
         q_ras.delete();
         sq_m = 1'b0;
      end else begin
         if (mis) begin
            q_ras.delete();
         end else if (act == APush || (act == ASwap && q_ras.size() == 0)) begin
            q_ras.push_back(a);
            if (q_ras.size() > RD) void'(q_ras.pop_front());
         end else if (act == ASwap) begin
            q_ras[$] = a;
         end else if (act == APop && q_ras.size() > 0) begin
            void'(q_ras.pop_back());
         end
         if (mis) sq_m = 1'b1;
         else if (resp) sq_m = 1'b0;
      end
   endtask

   task automatic set_nops();
      for (int i = 0; i < int'(FW); i++) slots[i] = mk(KOth, 0, 0, 0);
   endtask

   initial begin
      logic [31:0] pc;
      n_tests          = 0;
      n_fail           = 0;
      sq_m             = 1'b0;
      rst              = 1'b0;
      bus.imem_resp    = 1'b0;
      bus.mispredict   = 1'b0;
      bus.pc_late      = '0;
      bus.instruction  = '0;
      set_nops();

      // Reset with a JAL present: every output must stay 0.
      slots[0] = mk(KJal, 1, 0, 'h100);
      cycle(1'b0, 1'b1, 1'b0, 32'h1000);
      cycle(1'b0, 1'b1, 1'b0, 32'h1000);

      // Call then return.
      cycle(1'b1, 1'b1, 1'b0, 32'h1000);
      check("call_tgt", bus.pc_target_addr, 32'h0000_1100);
      check("call_jv1", 32'(bus.jump_valid1), 32'd1);
      slots[0] = mk(KJalr, 0, 1, 0);
      cycle(1'b1, 1'b1, 1'b0, 32'h1100);
`ifdef BP_RAS_EN
      check("ret_tgt", bus.pc_target_addr, 32'h0000_1004);
      check("ret_jv2", 32'(bus.jump_valid2), 32'd1);
`else
      check("ret_valid_off", 32'(bus.valid), 32'd0);
`endif
      cycle(1'b1, 1'b0, 1'b0, 32'h1200);
      check("ret_cnt", 32'(bus.ras_count), 32'd0);

      // Scan order: forward branch falls through, backward branch in slot 1 is taken.
      slots[0] = mk(KBr, 0, 2, 16);
      slots[1] = mk(KBr, 0, 2, -8);
      cycle(1'b1, 1'b1, 1'b0, 32'h2000);
      check("scan_tgt", bus.pc_target_addr, 32'h0000_1FFC);
      check("scan_slot", 32'(bus.slot_idx), 32'd1);

      // Overflow then underflow.
      set_nops();
      for (int k = 0; k < 9; k++) begin
         slots[0] = mk(KJal, 1, 0, 'h40);
         cycle(1'b1, 1'b1, 1'b0, 32'h3000 + 32'(k * 16));
      end
      slots[0] = mk(KJalr, 0, 1, 0);
      for (int k = 0; k < 9; k++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h5000);
`ifdef BP_RAS_EN
         if (k == 0) check("ovf_cnt", 32'(bus.ras_count), 32'd8);
         if (k < 8) check("lifo_tgt", bus.pc_target_addr, 32'h3000 + 32'((8 - k) * 16 + 4));
         else check("unf_valid", 32'(bus.valid), 32'd0);
`endif
      end
      cycle(1'b1, 1'b0, 1'b0, 32'h5000);
      check("unf_cnt", 32'(bus.ras_count), 32'd0);

      // Squash after a mispredict; a push beforehand must be flushed.
      slots[0] = mk(KJal, 1, 0, 'h80);
      cycle(1'b1, 1'b1, 1'b0, 32'h6000);
      cycle(1'b1, 1'b1, 1'b1, 32'h6000);
      check("sq_mis_valid", 32'(bus.valid), 32'd0);
      cycle(1'b1, 1'b1, 1'b0, 32'h6000);
      check("sq_stale_valid", 32'(bus.valid), 32'd0);
      check("sq_cnt", 32'(bus.ras_count), 32'd0);
      cycle(1'b1, 1'b1, 1'b0, 32'h6000);
      check("sq_resume_valid", 32'(bus.valid), 32'd1);

      // Mid-run reset discards the stack.
      for (int k = 0; k < 2; k++) cycle(1'b1, 1'b1, 1'b0, 32'h7000 + 32'(k * 8));
      cycle(1'b0, 1'b0, 1'b0, 32'h7100);
      slots[0] = mk(KOth, 0, 0, 0);
      slots[1] = mk(KJalr, 0, 5, 0);
      cycle(1'b1, 1'b1, 1'b0, 32'h7200);
      check("rst_ret_valid", 32'(bus.valid), 32'd0);
      check("rst_ret_slot", 32'(bus.slot_idx), 32'd1);
      check("rst_cnt", 32'(bus.ras_count), 32'd0);

      // Random packets.
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < int'(FW); i++) slots[i] = rnd_slot();
         pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 19) == 0), pc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
